// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: drives the PC write port, issues one
// outstanding imem request at a time, and hands instructions to decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    output logic        pc_we_o,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        trap_i,
    output logic        misalign_o,
    output logic [31:0] badaddr_o
);

    typedef enum logic [2:0] {BOOT, FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, instr_q, badaddr_q;
    logic        valid_q;

    logic active, evt, mis_redir, to_trap, accept;

    assign active    = (state_q != BOOT);
    assign evt       = active && (trap_i || redirect_valid_i);
    assign mis_redir = active && !trap_i && redirect_valid_i && (redirect_addr_i[1:0] != 2'b00);
    assign to_trap   = (active && trap_i) || mis_redir;
    assign accept    = ((state_q == FETCH) || (state_q == WAIT)) && imem_ack_i && !evt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:        state_d = FETCH;
            FETCH, WAIT: begin
                if (evt)             state_d = imem_ack_i ? FETCH : DRAIN;
                else if (imem_ack_i) state_d = HOLD;
                else                 state_d = WAIT;
            end
            HOLD:        if (evt || instr_ready_i) state_d = FETCH;
            DRAIN:       if (imem_ack_i) state_d = FETCH;
            default:     state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_we_o     = 1'b0;
        pc_next_o   = pc_i + 32'd4;
        imem_req_o  = (state_q == FETCH) || (state_q == WAIT) || (state_q == DRAIN);
        imem_addr_o = (state_q == FETCH) ? pc_i : addr_q;
        misalign_o  = mis_redir;
        if (state_q == BOOT) begin
            pc_we_o   = 1'b1;
            pc_next_o = RESET_VECTOR;
        end else if (to_trap) begin
            pc_we_o   = 1'b1;
            pc_next_o = TRAP_VECTOR;
        end else if (redirect_valid_i) begin
            pc_we_o   = 1'b1;
            pc_next_o = redirect_addr_i;
        end else if (accept) begin
            pc_we_o   = 1'b1;
        end
    end

    // addr_q captures the issued address so it stays stable through WAIT/DRAIN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q    <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            badaddr_q <= '0;
        end else begin
            if (state_q == FETCH) addr_q <= pc_i;
            if (accept) begin
                instr_q <= imem_rdata_i;
                valid_q <= 1'b1;
            end else if ((state_q == HOLD) && (evt || instr_ready_i)) begin
                valid_q <= 1'b0;
            end
            if (mis_redir) badaddr_q <= redirect_addr_i;
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign badaddr_o     = badaddr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register and a wait-state imem model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        req, ack;
    logic [31:0] addr, rdata, instr, badaddr;
    logic        ivalid, ready, redir, trap, misalign;
    logic [31:0] redir_addr;

    logic        mem_en;
    int          wait_n;
    int          wcnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100)) dut (
        .clk_i(clk), .reset_i(reset), .pc_i(pc), .pc_we_o(pc_we), .pc_next_o(pc_next),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .instr_o(instr), .instr_valid_o(ivalid), .instr_ready_i(ready),
        .redirect_valid_i(redir), .redirect_addr_i(redir_addr), .trap_i(trap),
        .misalign_o(misalign), .badaddr_o(badaddr)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // PC register, held in reset alongside the DUT
    always @(posedge clk or posedge reset)
        if (reset) pc <= '0;
        else if (pc_we) pc <= pc_next;

    assign ack   = req && mem_en && (wcnt == wait_n);
    assign rdata = memf(addr);

    always @(posedge clk)
        if (!req || ack) wcnt <= 0;
        else             wcnt <= wcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ready = 1'b1; redir = 1'b0; trap = 1'b0; redir_addr = '0;
        mem_en = 1'b1; wait_n = 0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_we", pc_we, 1);
        chk("rst_pc_next", pc_next, 32'h80);
        chk("rst_req", req, 0);
        chk("rst_valid", ivalid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_badaddr", badaddr, 0);
        chk("rst_misalign", misalign, 0);

        // cycle 0: BOOT
        @(negedge clk); reset = 1'b0; #1;
        chk("boot_pc_we", pc_we, 1);
        chk("boot_req", req, 0);
        // cycles 1..6: zero-wait fetches
        @(negedge clk); #1;
        chk("c1_req", req, 1);
        chk("c1_addr", addr, 32'h80);
        chk("c1_pc_next", pc_next, 32'h84);
        chk("c1_pc_we", pc_we, 1);
        @(negedge clk); #1;
        chk("c2_valid", ivalid, 1);
        chk("c2_instr", instr, memf(32'h80));
        chk("c2_req", req, 0);
        @(negedge clk); #1;
        chk("c3_addr", addr, 32'h84);
        chk("c3_valid", ivalid, 0);
        @(negedge clk); #1;
        chk("c4_instr", instr, memf(32'h84));
        @(negedge clk); #1;
        chk("c5_addr", addr, 32'h88);
        @(negedge clk); ready = 1'b0; wait_n = 3; #1;
        chk("c6_instr", instr, memf(32'h88));
        chk("c6_valid", ivalid, 1);

        // stall in HOLD for two cycles, then 3-wait fetch
        @(negedge clk); #1;
        chk("c7_valid", ivalid, 1);
        chk("c7_req", req, 0);
        @(negedge clk); ready = 1'b1; #1;
        chk("c8_valid", ivalid, 1);
        @(negedge clk); #1;
        chk("c9_addr", addr, 32'h8C);
        chk("c9_ack", ack, 0);
        for (int i = 10; i <= 12; i++) begin
            @(negedge clk); #1;
            chk("wait_addr", addr, 32'h8C);
            chk("wait_req", req, 1);
        end
        chk("c12_pc_next", pc_next, 32'h90);
        @(negedge clk); #1;
        chk("c13_instr", instr, memf(32'h8C));

        // redirect to 0x200 while waiting
        @(negedge clk); #1;
        chk("c14_addr", addr, 32'h90);
        @(negedge clk); redir = 1'b1; redir_addr = 32'h200; #1;
        chk("c15_pc_we", pc_we, 1);
        chk("c15_pc_next", pc_next, 32'h200);
        @(negedge clk); redir = 1'b0; #1;
        chk("c16_pc", pc, 32'h200);
        chk("c16_addr", addr, 32'h90);
        chk("c16_pc_we", pc_we, 0);
        @(negedge clk); #1;
        chk("c17_ack", ack, 1);
        chk("c17_addr", addr, 32'h90);
        chk("c17_pc_we", pc_we, 0);
        @(negedge clk); wait_n = 0; #1;
        chk("c18_valid", ivalid, 0);
        chk("c18_addr", addr, 32'h200);
        @(negedge clk); redir = 1'b1; redir_addr = 32'h202; #1;
        chk("c19_instr", instr, memf(32'h200));

        // misaligned redirect in HOLD
        chk("c19_misalign", misalign, 1);
        chk("c19_pc_next", pc_next, 32'h100);
        @(negedge clk); redir = 1'b1; redir_addr = 32'h300; trap = 1'b1; #1;
        chk("c20_misalign", misalign, 0);
        chk("c20_badaddr", badaddr, 32'h202);
        chk("c20_valid", ivalid, 0);
        chk("c20_addr", addr, 32'h100);
        // trap + redirect + ack together
        chk("c20_ack", ack, 1);
        chk("c20_pc_next", pc_next, 32'h100);
        @(negedge clk); redir = 1'b0; trap = 1'b0; #1;
        chk("c21_valid", ivalid, 0);
        chk("c21_addr", addr, 32'h100);
        @(negedge clk); redir = 1'b1; redir_addr = 32'hFFFF_FFFC; #1;
        chk("c22_instr", instr, memf(32'h100));

        // PC wrap
        @(negedge clk); redir = 1'b0; #1;
        chk("c23_addr", addr, 32'hFFFF_FFFC);
        chk("c23_pc_next", pc_next, 32'h0);
        @(negedge clk); #1;
        chk("c24_instr", instr, memf(32'hFFFF_FFFC));
        chk("c24_pc", pc, 32'h0);

        // reset pulsed while waiting
        @(negedge clk); wait_n = 3; #1;
        chk("c25_addr", addr, 32'h0);
        @(negedge clk); #1;
        chk("c26_req", req, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_req", req, 0);
        chk("arst_valid", ivalid, 0);
        chk("arst_pc_next", pc_next, 32'h80);
        @(negedge clk); reset = 1'b0; wait_n = 0; #1;
        chk("reboot_pc_we", pc_we, 1);
        chk("reboot_req", req, 0);
        @(negedge clk); #1;
        chk("reboot_addr", addr, 32'h80);
        chk("reboot_req1", req, 1);
        @(negedge clk); #1;
        chk("reboot_instr", instr, memf(32'h80));
        chk("reboot_valid", ivalid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller for the RISC-V softcore. It owns the program-counter write port (write enable plus next address) and issues requests to instruction memory. It hands fetched instructions to decode with a valid/ready handshake. It also applies branch/jump redirects and traps, including discarding an in-flight fetch when the PC is redirected underneath it.

## Interface
- RESET_VECTOR, 32'h00000000, PC value loaded in the first cycle after reset
- TRAP_VECTOR, 32'h00000100, PC value loaded on trap_i or a misaligned redirect
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  reset, asynchronous, active-high
- pc_i  in  32  current PC (program counter register output)
- pc_we_o  out  1  PC write enable, combinational
- pc_next_o  out  32  PC write data, combinational
- imem_req_o  out  1  fetch request, level; held until imem_ack_i
- imem_addr_o  out  32  fetch address, stable while imem_req_o is high
- imem_ack_i  in  1  memory response valid (may coincide with the first req cycle)
- imem_rdata_i  in  32  instruction word, valid with imem_ack_i
- instr_o  out  32  registered instruction to decode
- instr_valid_o  out  1  instr_o valid
- instr_ready_i  in  1  decode accepts instr_o
- redirect_valid_i  in  1  branch/jump taken, one-cycle pulse
- redirect_addr_i  in  32  redirect target
- trap_i  in  1  trap request, one-cycle pulse
- misalign_o  out  1  redirect target misaligned, combinational pulse
- badaddr_o  out  32  last misaligned target, registered

## Operation
- States:
  - BOOT: pc_we_o=1, pc_next_o=RESET_VECTOR, then go to FETCH unconditionally. Redirect and trap are ignored in BOOT.
  - FETCH: imem_req_o=1, imem_addr_o=pc_i, addr_q<=pc_i. On imem_ack_i go to ACCEPT handling; otherwise go to WAIT.
  - WAIT: imem_req_o=1, imem_addr_o=addr_q. Stay until imem_ack_i.
  - HOLD: instr_valid_o=1. On instr_ready_i go to FETCH.
  - DRAIN: imem_req_o=1, imem_addr_o=addr_q. On imem_ack_i discard the response and go to FETCH.
- ACCEPT, applied on the ack edge in FETCH or WAIT when there is no redirect or trap:
  - instr_o<=imem_rdata_i, instr_valid_o<=1.
  - pc_we_o=1, pc_next_o=pc_i+4 (mod 2^32; wraps from 32'hFFFFFFFC to 0).
  - Next state is HOLD.
- Event priority in FETCH, WAIT, HOLD and DRAIN: trap_i, then redirect_valid_i, then normal flow.
  - Trap: pc_we_o=1, pc_next_o=TRAP_VECTOR.
  - Redirect, aligned (redirect_addr_i[1:0]==0): pc_we_o=1, pc_next_o=redirect_addr_i.
  - Redirect, misaligned: treated as a trap. misalign_o=1 and badaddr_o<=redirect_addr_i.
- Next state after a trap or redirect:
  - From FETCH or WAIT with imem_ack_i: discard rdata, go to FETCH.
  - From FETCH or WAIT without imem_ack_i: go to DRAIN. Request and address stay unchanged; the PC already holds the new target.
  - From HOLD: instr_valid_o<=0 and go to FETCH. The held instruction is dropped even if instr_ready_i is high.
  - From DRAIN: update the PC. Stay in DRAIN until ack, or go to FETCH if ack arrives in the same cycle.
- pc_we_o=0 whenever no rule above asserts it.

## Timing
- Reset values:
  - State BOOT.
  - instr_o=0, instr_valid_o=0, addr_q=0, badaddr_o=0.
  - imem_req_o=0, misalign_o=0.
  - pc_we_o=1 and pc_next_o=RESET_VECTOR, which is harmless because the PC is itself held in reset.
- Reset asserted mid-operation aborts immediately: any outstanding memory request is abandoned and the memory side must tolerate req dropping.
- Zero-wait memory (ack in the FETCH cycle): instr_valid_o and PC+4 are both visible one edge after FETCH.
  - Best-case throughput is 1 instruction per 2 cycles (FETCH, HOLD with ready high).
- Each wait cycle on imem_ack_i adds 1 cycle to fetch latency.
- imem_addr_o must not change while imem_req_o is high and imem_ack_i is low, including across a redirect.
- At most one outstanding request; a new request is issued only from FETCH.
- misalign_o is high only in the cycle of the offending redirect.

## Test plan
- Boot with RESET_VECTOR=32'h80, zero-wait memory, ready always high:
  - Addresses 0x80, 0x84, 0x88 are issued on cycles 1, 3, 5.
  - instr_o values match memory, each valid for 1 cycle.
- Memory with 3 wait cycles and ready held low for 2 cycles in HOLD:
  - imem_addr_o stays stable throughout the wait.
  - instr_valid_o stays high until ready; no extra request is issued.
- Redirect to 0x200 in WAIT, then ack 2 cycles later:
  - PC becomes 0x200 immediately.
  - The late rdata is never presented; the next request address is 0x200.
- Redirect to 0x202:
  - PC becomes 0x100 (TRAP_VECTOR), misalign_o pulses once, badaddr_o=0x202.
- Simultaneous trap_i, redirect to 0x300 and imem_ack_i in FETCH:
  - PC becomes 0x100, rdata is discarded, next fetch is from 0x100.
- PC at 0xFFFFFFFC, ack:
  - pc_next_o=0x00000000.
- reset_i pulsed in WAIT:
  - imem_req_o drops asynchronously and instr_valid_o=0.
  - The sequence then restarts at RESET_VECTOR.
